// File: rtl/weights_loader.sv
// weights_loader: turns a byte stream into little-endian 16-bit words and
//   writes them through port A of the weights memory, tracking count and checksum.
// Latency: 3 cycles per word at best (LO byte, HI byte, WRITE); done one cycle after the last write.
// Backpressure: byte_ready is high only in LO/HI, so the stream stalls during WRITE, IDLE and DONE.
//
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   start, abort             - load request (IDLE only) and cancel (busy states only)
//   base_addr, word_count    - first word address and number of words, latched on start
//   byte_in/byte_valid/ready - incoming byte stream handshake
//   mem_address/data/wren    - port-A write path; mem_select=0 while the loader owns port A
//   busy, done               - load in progress / one-cycle completion pulse
//   words_written, checksum  - progress and modulo-2^16 sum since the last start
module weights_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_select,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_written,
  output logic [DATA_WIDTH-1:0] checksum
);

  // The memory holds 2^ADDR_WIDTH words, so a larger request is cut to that.
  localparam int                   MAX_WORDS = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [7:0]            lo_byte_q;
  logic [CNT_WIDTH-1:0]  count_clamped;
  logic [CNT_WIDTH-1:0]  written_inc;
  logic                  xfer;

  assign count_clamped = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
  assign written_inc   = words_written + CNT_WIDTH'(1);
  assign xfer          = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    mem_wren   = 1'b0;
    mem_select = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (count_clamped == '0) ? DONE : LO;
      end
      LO: begin
        byte_ready = 1'b1;
        mem_select = 1'b0;
        busy       = 1'b1;
        if (byte_valid) state_d = HI;
      end
      HI: begin
        byte_ready = 1'b1;
        mem_select = 1'b0;
        busy       = 1'b1;
        if (byte_valid) state_d = WRITE;
      end
      WRITE: begin
        mem_wren   = 1'b1;
        mem_select = 1'b0;
        busy       = 1'b1;
        state_d    = (written_inc == count_q) ? DONE : LO;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort only redirects the next state; this cycle's outputs (including a
    // WRITE strobe) still take effect.
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q        <= '0;
      count_q       <= '0;
      lo_byte_q     <= '0;
      mem_address   <= '0;
      mem_data      <= '0;
      words_written <= '0;
      checksum      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q        <= base_addr;
            count_q       <= count_clamped;
            words_written <= '0;
            checksum      <= '0;
          end
        end
        LO: begin
          if (xfer) lo_byte_q <= byte_in;
        end
        HI: begin
          if (xfer) begin
            mem_data    <= {byte_in, lo_byte_q};
            // Truncation to ADDR_WIDTH gives the silent wrap past the top word.
            mem_address <= base_q + words_written[ADDR_WIDTH-1:0];
          end
        end
        WRITE: begin
          words_written <= written_inc;
          checksum      <= checksum + mem_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weights_loader.sv
// tb_weights_loader: directed checks of weights_loader using a vector table
//   for two-word loads plus hand sequences for reset, zero count, abort and clamp.
// Inputs are driven just after the falling edge; outputs are sampled there too.
module tb_weights_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [12:0] base_addr;
  logic [13:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [12:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren, mem_select, busy, done;
  logic [13:0] words_written;
  logic [15:0] checksum;

  weights_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .mem_select   (mem_select),
    .busy         (busy),
    .done         (done),
    .words_written(words_written),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [28:0] wq[$];
  int          wcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wren) begin
      wq.push_back({mem_address, mem_data});
      wcyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [12:0] b, input logic [13:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents a byte (after an optional random idle gap) and returns just
  // after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g, n;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    if (g > 0) begin
      byte_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    byte_in = b; byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin @(negedge clk); n++; end
    if (!byte_ready) chk("byte_accept_timeout", 32'(n), 32'(0));
    else @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(busy), 32'(0));
    #1;
  endtask

  typedef struct {
    logic [12:0] base;
    logic [15:0] w0, w1;
    int          maxgap;
    logic [12:0] a0, a1;
    logic [15:0] sum;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
    byte_in = '0; byte_valid = 1'b0;

    vecs[0] = '{13'h0010, 16'h1234, 16'h5678, 0, 13'h0010, 13'h0011, 16'h68AC};
    vecs[1] = '{13'h1FFF, 16'hFFFF, 16'h0002, 0, 13'h1FFF, 13'h0000, 16'h0001};
    vecs[2] = '{13'h0010, 16'h1234, 16'h5678, 3, 13'h0010, 13'h0011, 16'h68AC};
    vecs[3] = '{13'h0ABC, 16'h8001, 16'h8000, 2, 13'h0ABC, 13'h0ABD, 16'h0001};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_byte_ready", 32'(byte_ready), 0);
    chk("rst_mem_wren",   32'(mem_wren), 0);
    chk("rst_mem_select", 32'(mem_select), 1);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_done",       32'(done), 0);
    chk("rst_mem_addr",   32'(mem_address), 0);
    chk("rst_mem_data",   32'(mem_data), 0);
    chk("rst_words",      32'(words_written), 0);
    chk("rst_checksum",   32'(checksum), 0);

    // Two-word loads from the table.
    for (int i = 0; i < 4; i++) begin
      wq.delete(); wcyc.delete();
      d0 = done_cnt;
      do_start(vecs[i].base, 14'd2);
      chk($sformatf("v%0d_busy", i), 32'(busy), 1);
      chk($sformatf("v%0d_select", i), 32'(mem_select), 0);
      send_byte(vecs[i].w0[7:0],  vecs[i].maxgap);
      send_byte(vecs[i].w0[15:8], vecs[i].maxgap);
      send_byte(vecs[i].w1[7:0],  vecs[i].maxgap);
      send_byte(vecs[i].w1[15:8], vecs[i].maxgap);
      byte_valid = 1'b0;
      wait_idle();
      chk($sformatf("v%0d_nwrites", i), 32'(wq.size()), 2);
      if (wq.size() == 2) begin
        chk($sformatf("v%0d_w0", i), 32'(wq[0]), 32'({vecs[i].a0, vecs[i].w0}));
        chk($sformatf("v%0d_w1", i), 32'(wq[1]), 32'({vecs[i].a1, vecs[i].w1}));
        chk($sformatf("v%0d_done_lat", i), 32'(done_cyc - wcyc[1]), 1);
      end
      chk($sformatf("v%0d_done_cnt", i), 32'(done_cnt - d0), 1);
      chk($sformatf("v%0d_words", i), 32'(words_written), 2);
      chk($sformatf("v%0d_checksum", i), 32'(checksum), 32'(vecs[i].sum));
      chk($sformatf("v%0d_select_idle", i), 32'(mem_select), 1);
    end

    // Byte held valid during WRITE must wait for the following LO cycle.
    wq.delete(); wcyc.delete();
    do_start(13'h0040, 14'd2);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    byte_in = 8'h78; byte_valid = 1'b1;
    chk("bp_write_wren",  32'(mem_wren), 1);
    chk("bp_write_ready", 32'(byte_ready), 0);
    @(negedge clk);
    chk("bp_lo_ready", 32'(byte_ready), 1);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    byte_valid = 1'b0;
    wait_idle();
    chk("bp_nwrites", 32'(wq.size()), 2);
    if (wq.size() == 2) begin
      chk("bp_w0", 32'(wq[0]), 32'({13'h0040, 16'h1234}));
      chk("bp_w1", 32'(wq[1]), 32'({13'h0041, 16'h5678}));
    end
    chk("bp_checksum", 32'(checksum), 32'h68AC);

    // Zero count, with abort asserted alongside start (start wins).
    wq.delete(); wcyc.delete();
    d0 = done_cnt;
    abort = 1'b1;
    do_start(13'h0123, 14'd0);
    abort = 1'b0;
    chk("zero_done",   32'(done), 1);
    chk("zero_select", 32'(mem_select), 1);
    chk("zero_wren",   32'(mem_wren), 0);
    chk("zero_words",  32'(words_written), 0);
    chk("zero_sum",    32'(checksum), 0);
    @(negedge clk);
    chk("zero_done_end", 32'(done), 0);
    chk("zero_busy_end", 32'(busy), 0);
    #1;
    chk("zero_nwrites", 32'(wq.size()), 0);
    chk("zero_done_cnt", 32'(done_cnt - d0), 1);

    // Abort after three bytes, with an ignored start while busy.
    wq.delete(); wcyc.delete();
    d0 = done_cnt;
    do_start(13'h0100, 14'd4);
    send_byte(8'h11, 0);
    byte_valid = 1'b0;
    start = 1'b1; base_addr = 13'h0200; word_count = 14'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    abort = 1'b1; byte_in = 8'h44; byte_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; byte_valid = 1'b0;
    chk("abort_busy",   32'(busy), 0);
    chk("abort_select", 32'(mem_select), 1);
    chk("abort_ready",  32'(byte_ready), 0);
    repeat (4) @(negedge clk);
    #1;
    chk("abort_nwrites", 32'(wq.size()), 1);
    if (wq.size() == 1) chk("abort_w0", 32'(wq[0]), 32'({13'h0100, 16'h2211}));
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_words",   32'(words_written), 1);
    chk("abort_sum",     32'(checksum), 32'h2211);

    // Abort in the WRITE cycle: the write still lands and is counted.
    wq.delete(); wcyc.delete();
    d0 = done_cnt;
    do_start(13'h0005, 14'd3);
    send_byte(8'hCD, 0);
    send_byte(8'hAB, 0);
    byte_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortw_busy",  32'(busy), 0);
    chk("abortw_words", 32'(words_written), 1);
    chk("abortw_sum",   32'(checksum), 32'hABCD);
    repeat (3) @(negedge clk);
    #1;
    chk("abortw_nwrites", 32'(wq.size()), 1);
    chk("abortw_no_done", 32'(done_cnt - d0), 0);

    // Count above the memory size is clamped to 8192 words; word i = i.
    wq.delete(); wcyc.delete();
    d0 = done_cnt;
    do_start(13'h0000, 14'd9000);
    for (int i = 0; i < 8192; i++) begin
      send_byte(8'(i), 0);
      send_byte(8'(i >> 8), 0);
    end
    byte_valid = 1'b0;
    wait_idle();
    chk("clamp_nwrites", 32'(wq.size()), 8192);
    if (wq.size() == 8192) chk("clamp_last", 32'(wq[8191]), 32'({13'h1FFF, 16'h1FFF}));
    chk("clamp_words",    32'(words_written), 8192);
    chk("clamp_sum",      32'(checksum), 32'hF000);
    chk("clamp_done_cnt", 32'(done_cnt - d0), 1);

    // Reset in the middle of a load.
    wq.delete(); wcyc.delete();
    do_start(13'h0300, 14'd4);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    byte_in = 8'h04; byte_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready",  32'(byte_ready), 0);
    chk("mid_rst_wren",   32'(mem_wren), 0);
    chk("mid_rst_select", 32'(mem_select), 1);
    chk("mid_rst_busy",   32'(busy), 0);
    chk("mid_rst_words",  32'(words_written), 0);
    chk("mid_rst_sum",    32'(checksum), 0);
    #1;
    wq.delete(); wcyc.delete();
    repeat (5) @(negedge clk);
    #1;
    byte_valid = 1'b0;
    chk("mid_rst_no_writes", 32'(wq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
